if_id_skid_reg: RTL and testbench
=================================

// Module: if_id_skid_reg
// PURPOSE
//  Parametrised IF->ID pipeline register with valid/ready handshake and 2-entry skid buffer.
//  Fetch can push every cycle while decode back-pressures, with no combinational ready path.
//  Sits between fetch (PC+2 / instruction) and decode; flush squashes all held entries.
//  Empty slots present the NOP encoding to decode.
// PARAMETERS
//  PC_W      16      width of incremented-PC field
//  INSTR_W   16      width of instruction field
//  NOP_INSTR 'h0000  encoding driven on dn_instr when no valid entry (INSTR_W bits)
//  CNT_W     16      perf counter width (used only with IF_ID_SKID_PERF_EN)
// PORTS
//  clk         in   1        clock, all state on rising edge
//  rst         in   1        synchronous reset, active-high
//  up_valid    in   1        fetch presents an entry
//  up_ready    out  1        register can accept an entry this cycle
//  up_pc       in   PC_W     incremented PC from fetch
//  up_instr    in   INSTR_W  instruction from fetch
//  dn_valid    out  1        entry valid toward decode
//  dn_ready    in   1        decode consumes entry (0 = stall)
//  dn_pc       out  PC_W     PC of head entry
//  dn_instr    out  INSTR_W  instruction of head entry, NOP_INSTR when dn_valid=0
//  flush       in   1        squash all entries (branch/jump taken)
//  stall_cnt   out  CNT_W    [IF_ID_SKID_PERF_EN only] cycles with dn_valid & ~dn_ready
//  flush_cnt   out  CNT_W    [IF_ID_SKID_PERF_EN only] cycles with flush=1
// BEHAVIOUR
//  - Storage: head reg (drives dn_*) + skid reg; state EMPTY / ONE / TWO.
//  - up_xfer = up_valid & up_ready; dn_xfer = dn_valid & dn_ready.
//  - up_ready = (state != TWO) & ~rst; decoded from registered state only.
//  - dn_valid = (state != EMPTY); dn_pc/dn_instr come straight from head reg.
//  - Latency: entry accepted at edge N appears on dn_* after edge N (1 cycle).
//  - EMPTY: up_xfer -> ONE, head<=up.  else stay.
//  - ONE: up&dn -> ONE, head<=up; up only -> TWO, skid<=up; dn only -> EMPTY; none: hold.
//  - TWO: dn_xfer -> ONE, head<=skid; else hold (up_ready=0, no up_xfer).
//  - Ordering strictly FIFO; no entry dropped or duplicated except by flush.
//  - flush (priority over all transfers): next state EMPTY, head instr<=NOP_INSTR,
//    head pc held, skid invalidated; an up_xfer in the same cycle is discarded.
//    A dn_xfer in the flush cycle still counts as consumed by decode.
//  - dn_instr = NOP_INSTR whenever state = EMPTY (including after a dn-only drain).
//  - rst: state EMPTY, dn_valid=0, dn_pc=0, dn_instr=NOP_INSTR, skid cleared,
//    up_ready=0 while rst=1; rst mid-operation discards all entries, beats flush.
//  - Widths are independent; no arithmetic on PC (PC stored as given).
// CONFIGURATION
//  - IF_ID_SKID_PERF_EN defined: stall_cnt and flush_cnt ports exist; each increments by 1
//    on qualifying cycle, saturates at all-ones, clears on rst.
//  - Not defined: ports and counters absent; datapath identical in both builds.
// TESTING
//  - rst=1 two cycles -> dn_valid=0, dn_instr=0000, dn_pc=0000, up_ready=0; rst=0 -> up_ready=1.
//  - Stream pc=0002..00FE, instr=pc, dn_ready=1 -> each appears on dn_* one cycle later, no gaps.
//  - Push A=1111,B=2222,C=3333 with dn_ready=0 -> A,B held, up_ready=0 after B, C stalls;
//    dn_ready=1 -> dn sees A,B,C in order, one per cycle.
//  - State TWO (A,B held), flush=1 with up_valid=1 pc=4444 -> next cycle dn_valid=0,
//    dn_instr=0000, 4444 not captured, up_ready=1.
//  - Push 5555 then dn-only drain -> EMPTY, dn_instr=NOP_INSTR; NOP_INSTR='h0800 rebuild -> 0800.
//  - PERF_EN, CNT_W=4: hold dn_ready=0 with valid for 20 cycles -> stall_cnt=F (saturated);
//    3 flush pulses -> flush_cnt=3; rst -> both 0.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with a 2-entry skid buffer; 1-cycle latency, up_ready comes from registered state only.
// Optional stall/flush performance counters are enabled by defining IF_ID_SKID_PERF_EN.
module if_id_skid_reg #(
    parameter int                 PC_W      = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic [PC_W-1:0]    up_pc,
    input  logic [INSTR_W-1:0] up_instr,
    output logic               dn_valid,
    input  logic               dn_ready,
    output logic [PC_W-1:0]    dn_pc,
    output logic [INSTR_W-1:0] dn_instr,
    input  logic               flush
`ifdef IF_ID_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               up_xfer;
    logic               dn_xfer;
    logic               load_head_up;
    logic               load_head_skid;
    logic               load_skid;
    logic [PC_W-1:0]    head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    assign up_xfer = up_valid & up_ready;
    assign dn_xfer = dn_valid & dn_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_head_up   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (up_xfer) begin
                        state_nxt    = ONE;
                        load_head_up = 1'b1;
                    end
                end
                ONE: begin
                    if (up_xfer && dn_xfer) begin
                        load_head_up = 1'b1;
                    end else if (up_xfer) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (dn_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (dn_xfer) begin
                        state_nxt      = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Outputs decode registered state only, so ready never depends combinationally on dn_ready.
    always_comb begin
        up_ready = (state != TWO) & ~rst;
        dn_valid = (state != EMPTY);
        dn_pc    = head_pc;
        dn_instr = (state == EMPTY) ? NOP_INSTR : head_instr;
    end

    // Flush leaves head_pc untouched; the skid entry is invalidated through the state alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_pc    <= '0;
            head_instr <= NOP_INSTR;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (flush) begin
            head_instr <= NOP_INSTR;
        end else begin
            if (load_head_up) begin
                head_pc    <= up_pc;
                head_instr <= up_instr;
            end else if (load_head_skid) begin
                head_pc    <= skid_pc;
                head_instr <= skid_instr;
            end
            if (load_skid) begin
                skid_pc    <= up_pc;
                skid_instr <= up_instr;
            end
        end
    end

`ifdef IF_ID_SKID_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (dn_valid && !dn_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: directed vector table, PC stream, then random traffic against a queue model.
module tb_if_id_skid_reg;

`ifdef IF_ID_SKID_PERF_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up_valid = 1'b0;
    logic        up_ready;
    logic        up_ready_n;
    logic [15:0] up_pc = '0;
    logic [15:0] up_instr = '0;
    logic        dn_valid;
    logic        dn_valid_n;
    logic        dn_ready = 1'b0;
    logic [15:0] dn_pc;
    logic [15:0] dn_pc_n;
    logic [15:0] dn_instr;
    logic [15:0] dn_instr_n;
    logic        flush = 1'b0;
`ifdef IF_ID_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt, stall_cnt_n, flush_cnt_n;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_id_skid_reg #(.PC_W(16), .INSTR_W(16), .NOP_INSTR(16'h0000), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
        .up_pc(up_pc), .up_instr(up_instr), .dn_valid(dn_valid), .dn_ready(dn_ready),
        .dn_pc(dn_pc), .dn_instr(dn_instr), .flush(flush)
`ifdef IF_ID_SKID_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // Second build with a non-zero NOP encoding, driven by the same stimulus.
    if_id_skid_reg #(.PC_W(16), .INSTR_W(16), .NOP_INSTR(16'h0800), .CNT_W(CNT_W)) dut_nop (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready_n),
        .up_pc(up_pc), .up_instr(up_instr), .dn_valid(dn_valid_n), .dn_ready(dn_ready),
        .dn_pc(dn_pc_n), .dn_instr(dn_instr_n), .flush(flush)
`ifdef IF_ID_SKID_PERF_EN
        , .stall_cnt(stall_cnt_n), .flush_cnt(flush_cnt_n)
`endif
    );

    // Reference: a FIFO of at most two {pc,instr} entries.
    logic [31:0] mq[$];
    int          m_stall = 0;
    int          m_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit had;
        bit rdy;
        had = (mq.size() > 0);
        rdy = (mq.size() < 2);
        if (rst) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (had && !dn_ready && m_stall < CNT_MAX) m_stall++;
            if (flush && m_flush < CNT_MAX) m_flush++;
            if (flush) begin
                mq.delete();
            end else begin
                if (had && dn_ready) void'(mq.pop_front());
                if (up_valid && rdy) mq.push_back({up_pc, up_instr});
            end
        end
    endtask

    task automatic model_check();
        logic [31:0] head;
        head = (mq.size() > 0) ? mq[0] : 32'h0;
        check("up_ready", {31'd0, up_ready}, {31'd0, (!rst && mq.size() < 2)});
        check("dn_valid", {31'd0, dn_valid}, {31'd0, (mq.size() > 0)});
        check("dn_instr", {16'd0, dn_instr}, (mq.size() > 0) ? {16'd0, head[15:0]} : 32'h0);
        check("nop_dn_instr", {16'd0, dn_instr_n}, (mq.size() > 0) ? {16'd0, head[15:0]} : 32'h0800);
        if (mq.size() > 0) check("dn_pc", {16'd0, dn_pc}, {16'd0, head[31:16]});
`ifdef IF_ID_SKID_PERF_EN
        check("stall_cnt", {28'd0, stall_cnt}, m_stall);
        check("flush_cnt", {28'd0, flush_cnt}, m_flush);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    task automatic drive(input logic r, input logic uv, input logic [15:0] pc,
                         input logic [15:0] ins, input logic dr, input logic fl);
        rst = r; up_valid = uv; up_pc = pc; up_instr = ins; dn_ready = dr; flush = fl;
    endtask

    typedef struct {
        logic        rst;
        logic        uv;
        logic [15:0] pc;
        logic [15:0] instr;
        logic        dr;
        logic        fl;
        logic        ev;
        logic        eur;
        logic [15:0] epc;
        logic [15:0] einstr;
        logic        cpc;
    } vec_t;

    vec_t vec[19];

    initial begin
        vec[0]  = '{1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 1};
        vec[1]  = '{1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 1};
        vec[2]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000, 1};
        vec[3]  = '{0, 1, 16'h1111, 16'h1111, 0, 0, 1, 1, 16'h1111, 16'h1111, 1};
        vec[4]  = '{0, 1, 16'h2222, 16'h2222, 0, 0, 1, 0, 16'h1111, 16'h1111, 1};
        vec[5]  = '{0, 1, 16'h3333, 16'h3333, 0, 0, 1, 0, 16'h1111, 16'h1111, 1};
        vec[6]  = '{0, 1, 16'h3333, 16'h3333, 1, 0, 1, 1, 16'h2222, 16'h2222, 1};
        vec[7]  = '{0, 1, 16'h3333, 16'h3333, 1, 0, 1, 1, 16'h3333, 16'h3333, 1};
        vec[8]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h3333, 16'h0000, 1};
        vec[9]  = '{0, 1, 16'h1111, 16'h1111, 0, 0, 1, 1, 16'h1111, 16'h1111, 1};
        vec[10] = '{0, 1, 16'h2222, 16'h2222, 0, 0, 1, 0, 16'h1111, 16'h1111, 1};
        vec[11] = '{0, 1, 16'h4444, 16'h4444, 0, 1, 0, 1, 16'h1111, 16'h0000, 1};
        vec[12] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h1111, 16'h0000, 1};
        vec[13] = '{0, 1, 16'h5555, 16'h5555, 0, 0, 1, 1, 16'h5555, 16'h5555, 1};
        vec[14] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h5555, 16'h0000, 1};
        vec[15] = '{0, 1, 16'h6666, 16'h6666, 0, 0, 1, 1, 16'h6666, 16'h6666, 1};
        vec[16] = '{0, 1, 16'h7777, 16'h7777, 0, 0, 1, 0, 16'h6666, 16'h6666, 1};
        vec[17] = '{1, 1, 16'h8888, 16'h8888, 0, 1, 0, 0, 16'h0000, 16'h0000, 1};
        vec[18] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000, 1};

        for (int i = 0; i < 19; i++) begin
            drive(vec[i].rst, vec[i].uv, vec[i].pc, vec[i].instr, vec[i].dr, vec[i].fl);
            step();
            check($sformatf("vec%0d_dn_valid", i), {31'd0, dn_valid}, {31'd0, vec[i].ev});
            check($sformatf("vec%0d_up_ready", i), {31'd0, up_ready}, {31'd0, vec[i].eur});
            check($sformatf("vec%0d_dn_instr", i), {16'd0, dn_instr}, {16'd0, vec[i].einstr});
            check($sformatf("vec%0d_nop_instr", i), {16'd0, dn_instr_n},
                  vec[i].ev ? {16'd0, vec[i].einstr} : 32'h0800);
            if (vec[i].cpc) check($sformatf("vec%0d_dn_pc", i), {16'd0, dn_pc}, {16'd0, vec[i].epc});
        end

        // Back-to-back stream with decode always ready: no bubbles.
        for (int p = 2; p <= 'hFE; p += 2) begin
            drive(0, 1, 16'(p), 16'(p), 1, 0);
            step();
            check("stream_valid", {31'd0, dn_valid}, 32'd1);
            check("stream_pc", {16'd0, dn_pc}, p);
            check("stream_instr", {16'd0, dn_instr}, p);
        end
        drive(0, 0, 16'h0, 16'h0, 1, 0);
        step();

`ifdef IF_ID_SKID_PERF_EN
        drive(1, 0, 16'h0, 16'h0, 0, 0);
        step();
        drive(0, 1, 16'h9999, 16'h9999, 0, 0);
        step();
        drive(0, 0, 16'h0, 16'h0, 0, 0);
        for (int c = 0; c < 20; c++) step();
        check("stall_sat", {28'd0, stall_cnt}, 32'hF);
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 16'h0, 16'h0, 0, 1);
            step();
            drive(0, 0, 16'h0, 16'h0, 0, 0);
            step();
        end
        check("flush_three", {28'd0, flush_cnt}, 32'd3);
        drive(1, 0, 16'h0, 16'h0, 0, 0);
        step();
        check("stall_rst", {28'd0, stall_cnt}, 32'd0);
        check("flush_rst", {28'd0, flush_cnt}, 32'd0);
`endif

        // Random traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), 16'($urandom), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 24) == 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
